// File: rtl/hdmi_i2c_seq.sv
// Sequencer that walks a register/value table and feeds the HDMI I2C write engine.
// Define HDMI_SEQ_RETRY_EN to resend a NACKed entry up to MAX_RETRY extra times.
module hdmi_i2c_seq #(
  parameter int unsigned CLK_DIV     = 2500,
  parameter logic [7:0]  SLAVE_ADDR  = 8'h72,
  parameter int unsigned N_REGS      = 31,
  parameter int unsigned AW          = 5,
  parameter int unsigned PWRUP_TICKS = 200,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic          clk,
  input  logic          rst,
  output logic          i2c_clk,
  output logic [23:0]   i2c_data,
  output logic          go,
  output logic          w_r,
  input  logic          end_in,
  input  logic          ack_in,
  output logic [AW-1:0] tbl_addr,
  input  logic [15:0]   tbl_data,
  input  logic          hpd,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int unsigned HALF = CLK_DIV / 2;
  localparam int unsigned CW   = $clog2(CLK_DIV);
  localparam int unsigned DW   = $clog2(PWRUP_TICKS + 1);
  localparam int unsigned RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

`ifdef HDMI_SEQ_RETRY_EN
  localparam int unsigned RETRY_LIMIT = MAX_RETRY;
`else
  localparam int unsigned RETRY_LIMIT = 0;
`endif

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_SETUP,
    ST_XFER,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            i2c_clk_q, i2c_clk_d;
  logic            pend_q, pend_d;
  logic            phase_q, phase_d;
  logic [DW-1:0]   delay_q, delay_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            nack_q, nack_d;
  logic            go_q, go_d;
  logic [23:0]     data_q, data_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            hpd_s1_q, hpd_s2_q, hpd_s3_q;
  logic            tick;
  logic            hpd_rise;

  // Synchroniser left unreset so a reset with the cable present is not seen as a plug-in.
  always_ff @(posedge clk) begin
    hpd_s1_q <= hpd;
    hpd_s2_q <= hpd_s1_q;
    hpd_s3_q <= hpd_s2_q;
  end

  always_comb begin
    cnt_d     = (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
    i2c_clk_d = (cnt_d < CW'(HALF));
    tick      = (cnt_q == CW'(HALF));
    hpd_rise  = hpd_s2_q & ~hpd_s3_q;
    // A plug-in between ticks is held until the next tick acts on it.
    pend_d    = (pend_q | hpd_rise) & ~tick;

    state_d = state_q;
    phase_d = phase_q;
    delay_d = delay_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    nack_d  = nack_q;
    go_d    = go_q;
    data_d  = data_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;

    if (tick) begin
      if (pend_q | hpd_rise) begin
        state_d = ST_PWRUP;
        phase_d = 1'b0;
        delay_d = '0;
        idx_d   = '0;
        retry_d = '0;
        go_d    = 1'b0;
        addr_d  = '0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        error_d = 1'b0;
      end else begin
        case (state_q)
          ST_PWRUP: begin
            busy_d = 1'b1;
            if (delay_q == DW'(PWRUP_TICKS - 1)) begin
              state_d = ST_SETUP;
              phase_d = 1'b0;
              addr_d  = idx_q;
            end else begin
              delay_d = delay_q + 1'b1;
            end
          end
          ST_SETUP: begin
            go_d   = 1'b0;
            addr_d = idx_q;
            if (phase_q) begin
              state_d = ST_XFER;
              phase_d = 1'b0;
            end else begin
              phase_d = 1'b1;
            end
          end
          ST_XFER: begin
            if (!phase_q) begin
              data_d  = {SLAVE_ADDR, tbl_data};
              go_d    = 1'b1;
              phase_d = 1'b1;
            end else if (end_in) begin
              nack_d  = ack_in;
              go_d    = 1'b0;
              state_d = ST_CHECK;
            end
          end
          ST_CHECK: begin
            go_d = 1'b0;
            if (!nack_q) begin
              if (idx_q == AW'(N_REGS - 1)) begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                idx_d   = idx_q + 1'b1;
                addr_d  = idx_q + 1'b1;
                retry_d = '0;
                phase_d = 1'b0;
                state_d = ST_SETUP;
              end
            end else if (retry_q != RW'(RETRY_LIMIT)) begin
              retry_d = retry_q + 1'b1;
              phase_d = 1'b0;
              state_d = ST_SETUP;
            end else begin
              state_d = ST_ERROR;
              busy_d  = 1'b0;
              error_d = 1'b1;
            end
          end
          ST_DONE: begin
            go_d   = 1'b0;
            busy_d = 1'b0;
          end
          ST_ERROR: begin
            go_d   = 1'b0;
            busy_d = 1'b0;
          end
          default: begin
            state_d = ST_PWRUP;
            delay_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      i2c_clk_q <= 1'b1;
      pend_q    <= 1'b0;
      state_q   <= ST_PWRUP;
      phase_q   <= 1'b0;
      delay_q   <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      nack_q    <= 1'b0;
      go_q      <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      i2c_clk_q <= i2c_clk_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      phase_q   <= phase_d;
      delay_q   <= delay_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      nack_q    <= nack_d;
      go_q      <= go_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign i2c_clk  = i2c_clk_q;
  assign i2c_data = data_q;
  assign go       = go_q;
  assign w_r      = 1'b0;
  assign tbl_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
